// File: rtl/apb_clk_cfg_bridge_if.sv
// apb_clk_cfg_bridge_if
//
// Bundles the two buses of the APB-to-clock-generator configuration bridge.
//   APB side       : psel_i, penable_i, pwrite_i, paddr_i[11:0], pwdata_i[31:0]
//                    prdata_o[31:0], pready_o, pslverr_o
//   Generator side : cfg_req_o, cfg_add_o[3:0], cfg_data_o[31:0], cfg_wrn_o
//                    cfg_ack_i, cfg_r_data_i[31:0]
// The _i/_o suffixes are taken from the bridge's point of view.
// The slave modport is the bridge.
// The master modport is whoever drives the APB bus and plays the generator.
interface apb_clk_cfg_bridge_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        cfg_req_o;
    logic        cfg_ack_i;
    logic [3:0]  cfg_add_o;
    logic [31:0] cfg_data_o;
    logic        cfg_wrn_o;
    logic [31:0] cfg_r_data_i;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  cfg_ack_i, cfg_r_data_i,
        output prdata_o, pready_o, pslverr_o,
        output cfg_req_o, cfg_add_o, cfg_data_o, cfg_wrn_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output cfg_ack_i, cfg_r_data_i,
        input  prdata_o, pready_o, pslverr_o,
        input  cfg_req_o, cfg_add_o, cfg_data_o, cfg_wrn_o
    );
endinterface

// File: rtl/apb_clk_cfg_bridge.sv
// apb_clk_cfg_bridge
//
// APB slave that turns register accesses into the req/ack configuration
// handshake of the clock generator. The APB transfer is stalled with
// pready_o low until the generator acknowledges. A timeout gives up on a
// dead or unclocked generator and records the event in a sticky STATUS bit.
//
// Ports
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : apb_clk_cfg_bridge_if.slave (APB slave + cfg request side)
//
// Address map (word index w = paddr_i[11:2])
//   w 0..15 : forwarded to the generator, cfg_add_o = w
//   w 16    : STATUS
//             bit0 TIMEOUT, sticky, write-1-to-clear
//             bit1 BUSY, always reads 0
//   other   : decode error, returns ERR_RDATA with pslverr_o
module apb_clk_cfg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hdeadda7a
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    apb_clk_cfg_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              cfg_req_q, cfg_req_d;
    logic [3:0]        cfg_add_q, cfg_add_d;
    logic [31:0]       cfg_data_q, cfg_data_d;
    logic              cfg_wrn_q, cfg_wrn_d;
    logic              timeout_q, timeout_d;

    logic [9:0]        word_idx;
    logic              is_fwd;
    logic              is_status;
    logic              access;
    logic              unused_paddr_lsb;

    assign word_idx  = bus.paddr_i[11:2];
    assign is_fwd    = (word_idx[9:4] == 6'd0);
    assign is_status = (word_idx == 10'd16);
    assign access    = bus.psel_i & bus.penable_i;

    // Byte-lane bits carry no meaning for word registers.
    assign unused_paddr_lsb = ^bus.paddr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            cfg_req_q  <= 1'b0;
            cfg_add_q  <= '0;
            cfg_data_q <= '0;
            cfg_wrn_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            cfg_req_q  <= cfg_req_d;
            cfg_add_q  <= cfg_add_d;
            cfg_data_q <= cfg_data_d;
            cfg_wrn_q  <= cfg_wrn_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prdata_d   = prdata_q;
        pslverr_d  = pslverr_q;
        cfg_req_d  = cfg_req_q;
        cfg_add_d  = cfg_add_q;
        cfg_data_d = cfg_data_q;
        cfg_wrn_d  = cfg_wrn_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (is_fwd) begin
                        cfg_add_d  = word_idx[3:0];
                        cfg_data_d = bus.pwdata_i;
                        cfg_wrn_d  = bus.pwrite_i;
                        cfg_req_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_REQ;
                    end else if (is_status) begin
                        pslverr_d = 1'b0;
                        if (bus.pwrite_i) begin
                            prdata_d = '0;
                            // The clear is visible from the RESP cycle on.
                            // No timeout can race it, because local accesses
                            // never enter REQ.
                            if (bus.pwdata_i[0]) begin
                                timeout_d = 1'b0;
                            end
                        end else begin
                            prdata_d = {30'd0, 1'b0, timeout_q};
                        end
                        state_d = ST_RESP;
                    end else begin
                        pslverr_d = 1'b1;
                        prdata_d  = ERR_RDATA;
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is checked first so an ack on the final cycle still succeeds.
                if (bus.cfg_ack_i) begin
                    cfg_req_d = 1'b0;
                    prdata_d  = cfg_wrn_q ? 32'd0 : bus.cfg_r_data_i;
                    pslverr_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cfg_req_d = 1'b0;
                    prdata_d  = ERR_RDATA;
                    pslverr_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pready_o   = (state_q == ST_RESP);
    assign bus.prdata_o   = prdata_q;
    assign bus.pslverr_o  = pslverr_q;
    assign bus.cfg_req_o  = cfg_req_q;
    assign bus.cfg_add_o  = cfg_add_q;
    assign bus.cfg_data_o = cfg_data_q;
    assign bus.cfg_wrn_o  = cfg_wrn_q;

endmodule

// File: tb/tb_apb_clk_cfg_bridge.sv
module tb_apb_clk_cfg_bridge;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   req_cycles;

    apb_clk_cfg_bridge_if bus ();

    apb_clk_cfg_bridge #(
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hdeadda7a)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Setup phase, then raise penable; the current cycle becomes T0.
    task automatic apb_start(input logic wr, input logic [11:0] addr, input logic [31:0] data);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = wr;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        tick();
        bus.penable_i = 1'b1;
    endtask

    task automatic apb_end();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        tick();
    endtask

    // Counts REQ cycles and raises ack on the ack_at-th one (0 = never).
    task automatic run_req(input int ack_at, input logic [31:0] rdata, output int n);
        n = 0;
        for (int i = 0; i < 40 && bus.cfg_req_o === 1'b1; i++) begin
            n++;
            bus.cfg_ack_i    = (n == ack_at);
            bus.cfg_r_data_i = rdata;
            tick();
        end
        bus.cfg_ack_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.psel_i       = 1'b0;
        bus.penable_i    = 1'b0;
        bus.pwrite_i     = 1'b0;
        bus.paddr_i      = '0;
        bus.pwdata_i     = '0;
        bus.cfg_ack_i    = 1'b0;
        bus.cfg_r_data_i = '0;

        // Reset state
        tick();
        tick();
        check("rst_pready",   bus.pready_o,   32'd0);
        check("rst_pslverr",  bus.pslverr_o,  32'd0);
        check("rst_prdata",   bus.prdata_o,   32'd0);
        check("rst_cfg_req",  bus.cfg_req_o,  32'd0);
        check("rst_cfg_add",  bus.cfg_add_o,  32'd0);
        check("rst_cfg_data", bus.cfg_data_o, 32'd0);
        check("rst_cfg_wrn",  bus.cfg_wrn_o,  32'd0);
        rst_n = 1'b1;
        tick();

        // Write 0x12345678 to 0x08, ack tied high (ignored while idle)
        bus.cfg_ack_i = 1'b1;
        apb_start(1'b1, 12'h008, 32'h12345678);
        check("wr_t0_pready", bus.pready_o, 32'd0);
        tick();
        check("wr_t1_req",    bus.cfg_req_o,  32'd1);
        check("wr_t1_add",    bus.cfg_add_o,  32'd2);
        check("wr_t1_wrn",    bus.cfg_wrn_o,  32'd1);
        check("wr_t1_data",   bus.cfg_data_o, 32'h12345678);
        check("wr_t1_pready", bus.pready_o,   32'd0);
        tick();
        check("wr_t2_pready",  bus.pready_o,  32'd1);
        check("wr_t2_pslverr", bus.pslverr_o, 32'd0);
        check("wr_t2_req",     bus.cfg_req_o, 32'd0);
        check("wr_t2_prdata",  bus.prdata_o,  32'd0);
        bus.cfg_ack_i = 1'b0;
        apb_end();
        check("wr_idle_pready", bus.pready_o, 32'd0);

        // Read 0x3C, ack on the 6th request cycle
        apb_start(1'b0, 12'h03C, 32'h0);
        tick();
        check("rd_add", bus.cfg_add_o, 32'd15);
        check("rd_wrn", bus.cfg_wrn_o, 32'd0);
        run_req(6, 32'hdeadda7a, req_cycles);
        check("rd_req_cycles", req_cycles,    32'd6);
        check("rd_pready",     bus.pready_o,  32'd1);
        check("rd_prdata",     bus.prdata_o,  32'hdeadda7a);
        check("rd_pslverr",    bus.pslverr_o, 32'd0);
        apb_end();

        // Timeout: no ack at all
        apb_start(1'b0, 12'h000, 32'h0);
        tick();
        run_req(0, 32'h0, req_cycles);
        check("to_req_cycles", req_cycles,    32'd8);
        check("to_pready",     bus.pready_o,  32'd1);
        check("to_pslverr",    bus.pslverr_o, 32'd1);
        check("to_prdata",     bus.prdata_o,  32'hdeadda7a);
        apb_end();

        // STATUS read, clear, re-read
        apb_start(1'b0, 12'h040, 32'h0);
        tick();
        check("st_rd1_pready",  bus.pready_o,  32'd1);
        check("st_rd1_pslverr", bus.pslverr_o, 32'd0);
        check("st_rd1_prdata",  bus.prdata_o,  32'h1);
        apb_end();
        apb_start(1'b1, 12'h040, 32'h1);
        tick();
        check("st_wr_pready",  bus.pready_o,  32'd1);
        check("st_wr_pslverr", bus.pslverr_o, 32'd0);
        apb_end();
        apb_start(1'b0, 12'h040, 32'h0);
        tick();
        check("st_rd2_prdata", bus.prdata_o, 32'h0);
        apb_end();

        // Ack on the last allowed cycle wins over timeout
        apb_start(1'b0, 12'h010, 32'h0);
        tick();
        check("last_add", bus.cfg_add_o, 32'd4);
        run_req(8, 32'ha5a50f0f, req_cycles);
        check("last_req_cycles", req_cycles,    32'd8);
        check("last_pslverr",    bus.pslverr_o, 32'd0);
        check("last_prdata",     bus.prdata_o,  32'ha5a50f0f);
        apb_end();
        apb_start(1'b0, 12'h040, 32'h0);
        tick();
        check("last_status", bus.prdata_o, 32'h0);
        apb_end();

        // Decode error at 0x80
        apb_start(1'b0, 12'h080, 32'h0);
        check("err_t0_req", bus.cfg_req_o, 32'd0);
        tick();
        check("err_t1_pready",  bus.pready_o,  32'd1);
        check("err_t1_pslverr", bus.pslverr_o, 32'd1);
        check("err_t1_prdata",  bus.prdata_o,  32'hdeadda7a);
        check("err_t1_req",     bus.cfg_req_o, 32'd0);
        apb_end();
        check("err_idle_req", bus.cfg_req_o, 32'd0);

        // Reset asserted during REQ
        apb_start(1'b0, 12'h004, 32'h0);
        tick();
        check("rr_req_before", bus.cfg_req_o, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rr_req_async",    bus.cfg_req_o, 32'd0);
        check("rr_pready_async", bus.pready_o,  32'd0);
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        apb_start(1'b0, 12'h000, 32'h0);
        tick();
        check("rr_post_req", bus.cfg_req_o, 32'd1);
        check("rr_post_add", bus.cfg_add_o, 32'd0);
        run_req(1, 32'h0badf00d, req_cycles);
        check("rr_post_req_cycles", req_cycles,    32'd1);
        check("rr_post_pready",     bus.pready_o,  32'd1);
        check("rr_post_prdata",     bus.prdata_o,  32'h0badf00d);
        check("rr_post_pslverr",    bus.pslverr_o, 32'd0);
        apb_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_clk_cfg_bridge.md
# apb_clk_cfg_bridge

APB slave that converts processor register accesses into the request/acknowledge configuration handshake of the FPGA clock generator (`cfg_req`/`cfg_ack`/`cfg_add`/`cfg_data`/`cfg_wrn`/`cfg_r_data`). It sits directly upstream of the clock generator on the SoC peripheral bus. It holds each APB transfer with `pready_o` low until the generator acknowledges. A timeout with a sticky status bit keeps a dead or unclocked generator from hanging the bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of REQ cycles to wait for `cfg_ack_i`; 0 disables the timeout.
- `ERR_RDATA`, default 32'hdeadda7a: read data returned on timeout or decode error.
- `clk_i`  in  1  clock, single domain; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB enable.
- `pwrite_i`  in  1  APB write (1) / read (0).
- `paddr_i`  in  12  APB byte address; bits [1:0] ignored.
- `pwdata_i`  in  32  APB write data.
- `prdata_o`  out  32  APB read data, registered.
- `pready_o`  out  1  APB ready.
- `pslverr_o`  out  1  APB error, valid only while `pready_o`=1.
- `cfg_req_o`  out  1  configuration request to the clock generator.
- `cfg_ack_i`  in  1  configuration acknowledge from the clock generator.
- `cfg_add_o`  out  4  generator register index.
- `cfg_data_o`  out  32  generator write data.
- `cfg_wrn_o`  out  1  1 = write, 0 = read (generator convention).
- `cfg_r_data_i`  in  32  generator read data, valid with `cfg_ack_i`.

## Operation
- Address map (`paddr_i[11:2]` = word index w):
  - w 0..15 (0x00–0x3C): forwarded to the generator with `cfg_add_o` = w.
  - w 16 (0x40): local STATUS register.
    - bit0 TIMEOUT, sticky, write-1-to-clear.
    - bit1 BUSY, read-only, always 0 when read over APB.
    - bits [31:2] read 0.
  - All other w: decode error. `pslverr_o`=1, `prdata_o`=`ERR_RDATA`, no cfg request issued, writes ignored.
- FSM states:
  - IDLE: `pready_o`=0. On `psel_i & penable_i`, latch address, data and direction.
    - w 0..15: load `cfg_add_o`/`cfg_data_o`/`cfg_wrn_o` (= `pwrite_i`), set `cfg_req_o`=1, go REQ.
    - otherwise: go RESP with the local result.
  - REQ: `cfg_req_o` held at 1 with stable `cfg_add_o`/`cfg_data_o`/`cfg_wrn_o`. Counter increments each cycle.
    - On `cfg_ack_i`=1: capture `cfg_r_data_i` into `prdata_o` (reads; writes return 0), clear `cfg_req_o`, `pslverr_o`=0, go RESP.
    - On counter == `TIMEOUT_CYCLES`-1 with `cfg_ack_i`=0: clear `cfg_req_o`, `prdata_o`=`ERR_RDATA`, `pslverr_o`=1, set STATUS.TIMEOUT, go RESP.
  - RESP: `pready_o`=1 for exactly one cycle, then go IDLE. `prdata_o`/`pslverr_o` hold until the next response.
- Simultaneous events and protocol violations:
  - Ack and timeout in the same cycle: ack wins, no error, TIMEOUT not set.
  - `psel_i` dropping during REQ: handshake still completes normally and the result is discarded. RESP is still entered for one cycle.
  - `cfg_ack_i` outside REQ: ignored.
- STATUS write with bit0=1 clears TIMEOUT in the RESP cycle. A timeout setting TIMEOUT in the same cycle as a clear cannot occur, because local accesses never enter REQ.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit. The counter resets to 0 on every REQ entry.

## Timing
- Reset (asynchronous, `rst_ni`=0), all outputs and state:
  - FSM → IDLE, counter 0, STATUS.TIMEOUT 0.
  - `pready_o` 0, `pslverr_o` 0, `prdata_o` 0.
  - `cfg_req_o` 0, `cfg_add_o` 0, `cfg_data_o` 0, `cfg_wrn_o` 0.
- Reset asserted mid-transfer: `cfg_req_o` drops immediately and the APB transfer is abandoned.
- Forwarded access with immediate ack:
  - Access cycle T0 (IDLE decodes).
  - T1: `cfg_req_o`=1, ack sampled.
  - T2: `pready_o`=1.
  - Access phase is 3 cycles; each extra ack wait cycle adds 1.
- Local or error access: T0 decode, T1 `pready_o`=1, for a 2-cycle access phase.
- Timeout: `pready_o`=1 exactly `TIMEOUT_CYCLES`+1 cycles after T0.
- `cfg_req_o` is high for at least 1 cycle and at most `TIMEOUT_CYCLES` cycles per transfer.
- Back-to-back transfers: the next transfer may start in the cycle after RESP.

## Test plan
- Write 0x1234_5678 to 0x08 with ack tied 1:
  - `cfg_req_o` high one cycle with `cfg_add_o`=2, `cfg_wrn_o`=1, `cfg_data_o`=0x12345678.
  - `pready_o` 2 cycles after the access cycle, `pslverr_o`=0.
- Read 0x3C, ack delayed 5 cycles with `cfg_r_data_i`=0xdeadda7a:
  - `cfg_add_o`=15, `cfg_wrn_o`=0, `cfg_req_o` high 6 cycles.
  - `prdata_o`=0xdeadda7a, no error.
- `TIMEOUT_CYCLES`=8, ack never asserted:
  - `cfg_req_o` high 8 cycles, `pslverr_o`=1, `prdata_o`=0xdeadda7a.
  - STATUS read returns 0x1; writing 0x1 to 0x40 clears it and the next read returns 0x0.
- Ack asserted exactly on the last timeout cycle: no error, TIMEOUT stays 0, data captured.
- Access to 0x80: `pslverr_o`=1, `cfg_req_o` never asserted, `pready_o` in cycle T1.
- Assert `rst_ni`=0 during REQ: `cfg_req_o` and `pready_o` 0 at once; after release, a read of 0x00 completes normally.
